mem_access_stage: RTL and testbench

- MEM pipeline stage of the 5-stage MIPS core. Sits between the EX/MEM register and the MEM/WB register.
- Performs loads and stores (byte, half, word) over a req/ack data-memory bus and formats load data.
- Drives the MEM_* inputs of the MEM/WB register and raises a pipeline stall while a bus access is outstanding.
- Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_access_stage_pkg.sv | 26 ++
 rtl/mem_access_stage_load_formatter.sv | 31 +++
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access size codes, FSM state
// encoding and the default bus timeout.
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // A half needs addr[0]=0; a word (and the 2'b11 alias) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// Little-endian lane select of bus read data plus sign/zero extension.
module mem_access_stage_load_formatter
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half and extend it to 32 bits.
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on the req/ack data bus, stalls
// the front of the pipe while an access is outstanding, formats load data.
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops pass straight through
// BUSY  | dmem_req high, waiting for dmem_ack or timeout
// DONE  | access finished; present result to MEM/WB for one cycle
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_MemtoReg,
  input  logic        EX_RegWrite,
  input  logic [1:0]  EX_size,
  input  logic        EX_signed,
  input  logic [31:0] EX_ALU_res,
  input  logic [31:0] EX_wdata,
  input  logic [4:0]  EX_wreg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        mem_exc,
  output logic        MEM_MemtoReg,
  output logic        MEM_RegWrite,
  output logic [31:0] MEM_rdata,
  output logic [31:0] MEM_ALU_res,
  output logic [4:0]  MEM_wreg
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        abort_q, abort_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        mem_op, misaligned;
  logic [1:0]  lane;
  logic [31:0] ld_fmt, wdata_fmt, rdata_c;
  logic [3:0]  be_fmt;
  logic        stall_c, exc_c, regwrite_c, memtoreg_c;

  assign lane       = EX_ALU_res[1:0];
  assign mem_op     = EX_MemRead | EX_MemWrite;
  assign misaligned = is_misaligned(EX_size, lane);

  mem_access_stage_load_formatter u_load_formatter (
    .rdata_i  (dmem_rdata),
    .lane_i   (lane),
    .size_i   (EX_size),
    .signed_i (EX_signed),
    .data_o   (ld_fmt)
  );

  // Replicate store data across lanes and derive byte enables from the lane.
  always_comb begin
    case (EX_size)
      SZ_BYTE: begin
        be_fmt    = 4'b0001 << lane;
        wdata_fmt = {4{EX_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_fmt    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{EX_wdata[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = EX_wdata;
      end
    endcase
  end

  // Next-state logic and stage outputs; EX inputs are frozen while stalled,
  // so they stay valid for load formatting and for the DONE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_data_d  = ld_data_q;
    abort_d    = abort_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    stall_c    = 1'b0;
    exc_c      = 1'b0;
    regwrite_c = EX_RegWrite & ~EX_MemWrite;
    memtoreg_c = EX_MemtoReg;
    rdata_c    = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (mem_op && misaligned) begin
          exc_c      = 1'b1;
          regwrite_c = 1'b0;
          memtoreg_c = 1'b0;
        end else if (mem_op) begin
          stall_c    = 1'b1;
          regwrite_c = 1'b0;
          memtoreg_c = 1'b0;
          req_d      = 1'b1;
          we_d       = EX_MemWrite;
          addr_d     = {EX_ALU_res[31:2], 2'b00};
          be_d       = be_fmt;
          wdata_d    = wdata_fmt;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_c    = 1'b1;
        regwrite_c = 1'b0;
        memtoreg_c = 1'b0;
        if (dmem_ack) begin
          ld_data_d = ld_fmt;
          req_d     = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if ((TIMEOUT != 0) && (cnt_d == TIMEOUT_CNT)) begin
            abort_d   = 1'b1;
            ld_data_d = '0;
            req_d     = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rdata_c = ld_data_q;
        exc_c   = abort_q;
        if (abort_q) begin
          regwrite_c = 1'b0;
          memtoreg_c = 1'b0;
        end
        // Leave unconditionally so the instruction still in EX is not re-issued.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, captured load data and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ld_data_q <= '0;
      abort_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      abort_q   <= abort_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;

  // Control outputs read 0 while reset is held, even with a memory op in EX.
  assign stall        = stall_c & rst;
  assign mem_exc      = exc_c & rst;
  assign MEM_RegWrite = regwrite_c & rst;
  assign MEM_MemtoReg = memtoreg_c & rst;
  assign MEM_rdata    = rdata_c;
  assign MEM_ALU_res  = EX_ALU_res;
  assign MEM_wreg     = EX_wreg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (built with TIMEOUT=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite, EX_signed;
  logic [1:0]  EX_size;
  logic [31:0] EX_ALU_res, EX_wdata;
  logic [4:0]  EX_wreg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, mem_exc, MEM_MemtoReg, MEM_RegWrite;
  logic [31:0] MEM_rdata, MEM_ALU_res;
  logic [4:0]  MEM_wreg;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        regwrite;
    logic [7:0]  req;
    logic [7:0]  stall;
    logic [7:0]  exc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  exp_t exp_q[$];

  // observation of the most recent issue()
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic        o_regwrite, o_memtoreg, o_we, o_stable, o_timeout;
  logic [3:0]  o_be;
  logic [7:0]  o_req, o_stall, o_exc;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_MemtoReg(EX_MemtoReg),
    .EX_RegWrite(EX_RegWrite), .EX_size(EX_size), .EX_signed(EX_signed),
    .EX_ALU_res(EX_ALU_res), .EX_wdata(EX_wdata), .EX_wreg(EX_wreg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .mem_exc(mem_exc), .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
    .MEM_rdata(MEM_rdata), .MEM_ALU_res(MEM_ALU_res), .MEM_wreg(MEM_wreg)
  );

  always #5 clk = ~clk;

  // Reference load formatting written from the little-endian lane rules.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                              input logic [1:0] sz, input logic sg);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> {a[1:0], 3'b000};
    b  = sh[7:0];
    h  = a[1] ? rd[31:16] : rd[15:0];
    if (sz == 2'b00)      model_load = sg ? {{24{b[7]}}, b} : {24'h0, b};
    else if (sz == 2'b01) model_load = sg ? {{16{h[15]}}, h} : {16'h0, h};
    else                  model_load = rd;
  endfunction

  // Present one instruction in EX and play the bus slave until the stage
  // releases stall; ack is given on the ack_after-th request cycle (0 = never).
  task automatic issue(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input int ack_after, input logic [31:0] rdv);
    bit done;
    @(negedge clk);
    EX_MemRead = rd; EX_MemWrite = wr; EX_RegWrite = rw; EX_MemtoReg = m2r;
    EX_size = sz; EX_signed = sg; EX_ALU_res = a; EX_wdata = wd; EX_wreg = 5'd9;
    dmem_ack = 1'b0;
    o_req = 0; o_stall = 0; o_exc = 0; o_stable = 1'b1; done = 0;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
    o_rdata = '0; o_regwrite = 1'b0; o_memtoreg = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (mem_exc) o_exc++;
      if (dmem_req) begin
        if (o_req == 0) begin
          o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
        end else if (dmem_addr !== o_addr || dmem_be !== o_be || dmem_wdata !== o_wdata || dmem_we !== o_we) begin
          o_stable = 1'b0;
        end
        o_req++;
      end
      if (!stall) begin
        o_rdata = MEM_rdata; o_regwrite = MEM_RegWrite; o_memtoreg = MEM_MemtoReg;
        done = 1;
      end else begin
        o_stall++;
        if (dmem_req && ack_after != 0 && int'(o_req) == ack_after) begin
          dmem_ack = 1'b1; dmem_rdata = rdv;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
      end
    end
    o_timeout = !done;
  endtask

  task automatic set_nop();
    EX_MemRead = 0; EX_MemWrite = 0; EX_RegWrite = 0; EX_MemtoReg = 0;
    EX_size = 2'b10; EX_signed = 0; EX_ALU_res = 0; EX_wdata = 0; EX_wreg = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    set_nop();
    EX_MemRead = 1; EX_RegWrite = 1; EX_MemtoReg = 1; EX_ALU_res = 32'h100;
    #3;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
    tests_run++; if (mem_exc !== 1'b0) begin tests_failed++; $display("FAIL reset_exc: got %b want 0", mem_exc); end
    tests_run++; if (MEM_RegWrite !== 1'b0 || MEM_MemtoReg !== 1'b0) begin tests_failed++; $display("FAIL reset_wb: got %b%b want 00", MEM_RegWrite, MEM_MemtoReg); end
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h want all 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
    end
    set_nop();
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    set_nop();
    EX_RegWrite = 1; EX_ALU_res = 32'h1234_5678; EX_wreg = 5'd7;
    dmem_ack = 1'b1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL pass_stall: got %b want 0", stall); end
    tests_run++; if (MEM_RegWrite !== 1'b1 || MEM_MemtoReg !== 1'b0) begin tests_failed++; $display("FAIL pass_ctl: got rw=%b m2r=%b want 1 0", MEM_RegWrite, MEM_MemtoReg); end
    tests_run++; if (MEM_ALU_res !== 32'h1234_5678 || MEM_wreg !== 5'd7) begin tests_failed++; $display("FAIL pass_data: got %h/%0d want 12345678/7", MEM_ALU_res, MEM_wreg); end
    tests_run++; if (MEM_rdata !== 32'h0) begin tests_failed++; $display("FAIL pass_rdata: got %h want 0", MEM_rdata); end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL stray_ack: got req=%b stall=%b want 0 0", dmem_req, stall); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz[6]  = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        sg[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad[6]  = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    logic [31:0] rd[6]  = '{32'hDEADBEEF, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h12348001, 32'h00007F00};
    logic [3:0]  be[6]  = '{4'b1111, 4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
    int          ak[6]  = '{1, 1, 1, 2, 3, 1};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e = '{rdata: model_load(rd[i], ad[i], sz[i], sg[i]), regwrite: 1'b1, req: 8'(ak[i]),
            stall: 8'(ak[i] + 1), exc: 8'd0, addr: {ad[i][31:2], 2'b00}, be: be[i], wdata: 32'h0, we: 1'b0};
      exp_q.push_back(e);
      issue(1, 0, 1, 1, sz[i], sg[i], ad[i], 32'h0, ak[i], rd[i]);
      e = exp_q.pop_front();
      tests_run++; if (o_timeout) begin tests_failed++; $display("FAIL load_done[%0d]: stall never released", i); end
      tests_run++; if (o_rdata !== e.rdata) begin tests_failed++; $display("FAIL load_rdata[%0d]: got %h want %h", i, o_rdata, e.rdata); end
      tests_run++; if (o_regwrite !== e.regwrite || o_memtoreg !== 1'b1) begin tests_failed++; $display("FAIL load_wb[%0d]: got rw=%b m2r=%b want 1 1", i, o_regwrite, o_memtoreg); end
      tests_run++; if (o_stall !== e.stall || o_req !== e.req) begin tests_failed++; $display("FAIL load_timing[%0d]: got stall=%0d req=%0d want %0d %0d", i, o_stall, o_req, e.stall, e.req); end
      tests_run++; if (o_addr !== e.addr || o_be !== e.be || o_we !== e.we || !o_stable) begin tests_failed++; $display("FAIL load_bus[%0d]: got addr=%h be=%b we=%b stable=%b want %h %b %b 1", i, o_addr, o_be, o_we, o_stable, e.addr, e.be, e.we); end
    end
    // fixed points from the plan, independent of the model
    tests_run++; if (model_load(32'h80FF1234, 32'h103, 2'b00, 1'b1) !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL model_lb: got %h want ffffff80", model_load(32'h80FF1234, 32'h103, 2'b00, 1'b1)); end
  endtask

  task automatic test_stores();
    logic [1:0]  sz[3] = '{2'b01, 2'b00, 2'b10};
    logic [31:0] ad[3] = '{32'h202, 32'h101, 32'h10C};
    logic [31:0] wd[3] = '{32'h0000ABCD, 32'h1234565A, 32'hCAFEF00D};
    logic [31:0] ea[3] = '{32'h200, 32'h100, 32'h10C};
    logic [3:0]  eb[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ew[3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = '{rdata: 32'h0, regwrite: 1'b0, req: 8'd1, stall: 8'd2, exc: 8'd0,
            addr: ea[i], be: eb[i], wdata: ew[i], we: 1'b1};
      exp_q.push_back(e);
      issue(0, 1, 1, 0, sz[i], 1'b0, ad[i], wd[i], 1, 32'h0);
      e = exp_q.pop_front();
      tests_run++; if (o_timeout) begin tests_failed++; $display("FAIL store_done[%0d]: stall never released", i); end
      tests_run++; if (o_regwrite !== e.regwrite) begin tests_failed++; $display("FAIL store_rw[%0d]: got %b want 0", i, o_regwrite); end
      tests_run++; if (o_stall !== e.stall || o_req !== e.req) begin tests_failed++; $display("FAIL store_timing[%0d]: got stall=%0d req=%0d want %0d %0d", i, o_stall, o_req, e.stall, e.req); end
      tests_run++; if (o_addr !== e.addr || o_be !== e.be || o_wdata !== e.wdata || o_we !== e.we) begin tests_failed++; $display("FAIL store_bus[%0d]: got addr=%h be=%b wdata=%h we=%b want %h %b %h 1", i, o_addr, o_be, o_wdata, o_we, e.addr, e.be, e.wdata); end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz[2] = '{2'b10, 2'b01};
    logic [31:0] ad[2] = '{32'h101, 32'h103};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e = '{rdata: 32'h0, regwrite: 1'b0, req: 8'd0, stall: 8'd0, exc: 8'd1,
            addr: 32'h0, be: 4'h0, wdata: 32'h0, we: 1'b0};
      exp_q.push_back(e);
      issue(1, 0, 1, 1, sz[i], 1'b1, ad[i], 32'h0, 1, 32'h11111111);
      e = exp_q.pop_front();
      tests_run++; if (o_exc !== e.exc || o_stall !== e.stall || o_req !== e.req) begin tests_failed++; $display("FAIL misalign[%0d]: got exc=%0d stall=%0d req=%0d want 1 0 0", i, o_exc, o_stall, o_req); end
      tests_run++; if (o_regwrite !== e.regwrite) begin tests_failed++; $display("FAIL misalign_rw[%0d]: got %b want 0", i, o_regwrite); end
      issue(0, 0, 1, 0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h0);
      tests_run++; if (o_exc !== 8'd0 || o_req !== 8'd0 || o_regwrite !== 1'b1) begin tests_failed++; $display("FAIL misalign_after[%0d]: got exc=%0d req=%0d rw=%b want 0 0 1", i, o_exc, o_req, o_regwrite); end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    e = '{rdata: 32'h0, regwrite: 1'b0, req: 8'd4, stall: 8'd5, exc: 8'd1,
          addr: 32'h300, be: 4'hF, wdata: 32'h0, we: 1'b0};
    exp_q.push_back(e);
    issue(1, 0, 1, 1, 2'b10, 1'b0, 32'h300, 32'h0, 0, 32'h0);
    e = exp_q.pop_front();
    tests_run++; if (o_timeout) begin tests_failed++; $display("FAIL timeout_done: stall never released"); end
    tests_run++; if (o_req !== e.req || o_stall !== e.stall) begin tests_failed++; $display("FAIL timeout_timing: got req=%0d stall=%0d want %0d %0d", o_req, o_stall, e.req, e.stall); end
    tests_run++; if (o_exc !== e.exc || o_regwrite !== e.regwrite) begin tests_failed++; $display("FAIL timeout_exc: got exc=%0d rw=%b want 1 0", o_exc, o_regwrite); end
    issue(0, 0, 1, 0, 2'b10, 1'b0, 32'h44, 32'h0, 0, 32'h0);
    tests_run++; if (o_exc !== 8'd0 || o_stall !== 8'd0 || o_regwrite !== 1'b1) begin tests_failed++; $display("FAIL timeout_idle: got exc=%0d stall=%0d rw=%b want 0 0 1", o_exc, o_stall, o_regwrite); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e = '{rdata: 32'hA5A5_0001, regwrite: 1'b1, req: 8'd3, stall: 8'd4, exc: 8'd0,
          addr: 32'h104, be: 4'hF, wdata: 32'h0, we: 1'b0};
    exp_q.push_back(e);
    e = '{rdata: model_load(32'h9988_7766, 32'h106, 2'b01, 1'b0), regwrite: 1'b1, req: 8'd1, stall: 8'd2,
          exc: 8'd0, addr: 32'h104, be: 4'b1100, wdata: 32'h0, we: 1'b0};
    exp_q.push_back(e);
    issue(1, 0, 1, 1, 2'b10, 1'b0, 32'h104, 32'h0, 3, 32'hA5A5_0001);
    e = exp_q.pop_front();
    tests_run++; if (o_rdata !== e.rdata || o_stall !== e.stall || o_req !== e.req) begin tests_failed++; $display("FAIL b2b_first: got %h stall=%0d req=%0d want %h %0d %0d", o_rdata, o_stall, o_req, e.rdata, e.stall, e.req); end
    issue(1, 0, 1, 1, 2'b01, 1'b0, 32'h106, 32'h0, 1, 32'h9988_7766);
    e = exp_q.pop_front();
    tests_run++; if (o_rdata !== e.rdata || o_stall !== e.stall || o_be !== e.be) begin tests_failed++; $display("FAIL b2b_second: got %h stall=%0d be=%b want %h %0d %b", o_rdata, o_stall, o_be, e.rdata, e.stall, e.be); end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    set_nop();
    EX_MemRead = 1; EX_RegWrite = 1; EX_MemtoReg = 1; EX_ALU_res = 32'h400;
    @(negedge clk);
    #1;
    tests_run++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin tests_failed++; $display("FAIL busy_before_rst: got req=%b stall=%b want 1 1", dmem_req, stall); end
    rst = 1'b0;
    #1;
    tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL async_rst: got req=%b stall=%b want 0 0", dmem_req, stall); end
    @(negedge clk);
    rst = 1'b1;
    set_nop();
    EX_RegWrite = 1; EX_ALU_res = 32'h0000_0042; EX_wreg = 5'd3;
    #1;
    tests_run++; if (MEM_RegWrite !== 1'b1 || stall !== 1'b0 || MEM_ALU_res !== 32'h42) begin tests_failed++; $display("FAIL add_after_rst: got rw=%b stall=%b alu=%h want 1 0 00000042", MEM_RegWrite, stall, MEM_ALU_res); end
    @(negedge clk);
    #1;
    tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL no_reissue: got req=%b want 0", dmem_req); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
